// File: rtl/tt_game_pkg.sv
// tt_game_pkg: constants and FSM state type shared by the gamepad PMOD transmitter and receiver.
// No ports; provides FRAME_BITS, CTRL_BITS and state_t.
package tt_game_pkg;
    localparam int FRAME_BITS = 24;
    localparam int CTRL_BITS  = 12;
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;
endpackage

// File: rtl/tt_game_tx_if.sv
// tt_game_tx_if: control and three-wire gamepad signals of the transmitter.
// Signals: enable, controller_1, controller_2 (host -> transmitter);
//          game_clk_out, game_data, game_latch, busy, frame_done (transmitter -> host/receiver).
// Modports: master = transmitter side, slave = host/receiver side.
interface tt_game_tx_if;
    import tt_game_pkg::*;
    logic                 enable;
    logic [CTRL_BITS-1:0] controller_1;
    logic [CTRL_BITS-1:0] controller_2;
    logic                 game_clk_out;
    logic                 game_data;
    logic                 game_latch;
    logic                 busy;
    logic                 frame_done;
    modport master (
        input  enable, controller_1, controller_2,
        output game_clk_out, game_data, game_latch, busy, frame_done
    );
    modport slave (
        output enable, controller_1, controller_2,
        input  game_clk_out, game_data, game_latch, busy, frame_done
    );
endinterface

// File: rtl/tt_game_tx_clk_gate.sv
// game_clk_gate: AND-style clock gate kept as its own cell so the gated output is a generated clock.
// Ports: clk (in), en (in, must only change while clk is low), clk_out (out).
module game_clk_gate (
    input  logic clk,
    input  logic en,
    output logic clk_out
);
    assign clk_out = clk & en;
endmodule

// File: rtl/tt_game_tx.sv
// tt_game_tx: serialises {controller_2, controller_1} onto the latch/clock/data gamepad wires.
// Ports: game_clk (in, free-running bit clock), rstn (in, async active-low reset),
//        bus (tt_game_tx_if.master: enable, controller_1/2 in; game_clk_out, game_data,
//        game_latch, busy, frame_done out).
module tt_game_tx #(
    parameter int LATCH_CYCLES = 4,
    parameter int GAP_CYCLES   = 16
) (
    input logic          game_clk,
    input logic          rstn,
    tt_game_tx_if.master bus
);
    import tt_game_pkg::*;
    localparam int CW = $clog2((LATCH_CYCLES > GAP_CYCLES ? LATCH_CYCLES : GAP_CYCLES) + 1);
    state_t                state;
    logic                  en_meta, en_s, start;
    logic                  clk_en, data, latch, busy, frame_done;
    logic [4:0]            bit_cnt;
    logic [CW-1:0]         cnt;
    logic [FRAME_BITS-1:0] shreg;
    // Everything runs on the falling edge so clk_en only moves while game_clk is low.
    always_ff @(negedge game_clk or negedge rstn)
        if (!rstn) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            en_meta <= bus.enable;
            en_s    <= en_meta;
        end
    // A frame starts from IDLE or straight out of the last GAP edge (back-to-back).
    assign start = en_s && (state == IDLE || (state == GAP && cnt == '0));
    always_ff @(negedge game_clk or negedge rstn)
        if (!rstn) begin
            state      <= IDLE;
            clk_en     <= 1'b0;
            data       <= 1'b1;
            latch      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            cnt        <= '0;
            shreg      <= '1;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                state   <= SHIFT;
                shreg   <= {bus.controller_2, bus.controller_1};
                data    <= bus.controller_2[CTRL_BITS-1];
                clk_en  <= 1'b1;
                busy    <= 1'b1;
                bit_cnt <= '0;
            end else begin
                case (state)
                    SHIFT:
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            state  <= LATCH;
                            clk_en <= 1'b0;
                            data   <= 1'b1;
                            latch  <= 1'b1;
                            cnt    <= CW'(LATCH_CYCLES - 1);
                        end else begin
                            shreg   <= {shreg[FRAME_BITS-2:0], 1'b1};
                            data    <= shreg[FRAME_BITS-2];
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    LATCH:
                        if (cnt == '0) begin
                            state      <= GAP;
                            latch      <= 1'b0;
                            frame_done <= 1'b1;
                            cnt        <= CW'(GAP_CYCLES - 1);
                        end else
                            cnt <= cnt - 1'b1;
                    GAP:
                        if (cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else
                            cnt <= cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    game_clk_gate u_gate (
        .clk     (game_clk),
        .en      (clk_en),
        .clk_out (bus.game_clk_out)
    );
    assign bus.game_data  = data;
    assign bus.game_latch = latch;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_tt_game_tx.sv
// tb_tt_game_tx: directed + randomized bench for tt_game_tx with a receiver model and timing monitors.
module tb_tt_game_tx;
    import tt_game_pkg::*;
    logic game_clk = 1'b0;
    logic rstn     = 1'b0;
    logic rstn_b   = 1'b0;
    tt_game_tx_if a();
    tt_game_tx_if b();
    tt_game_tx dut (
        .game_clk (game_clk),
        .rstn     (rstn),
        .bus      (a.master)
    );
    tt_game_tx #(.LATCH_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .game_clk (game_clk),
        .rstn     (rstn_b),
        .bus      (b.master)
    );
    always #5 game_clk = ~game_clk;
    int tests = 0;
    int fails = 0;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(negedge game_clk);
        #1;
    endtask
    // Receiver model for the default build: shift on each forwarded clock pulse, take the
    // word when latch rises. The expected word is what the controllers showed on the
    // falling edge right before the first pulse of that frame.
    logic [23:0] rx_sh = '0, last_word = '0, ctrl_neg = '0;
    logic [23:0] exp_q[$];
    int pulses = 0, pulses_tot = 0, frames_rx = 0, lat_n = 0, done_n = 0;
    time t_rise = 0, latch_t = 0, latch_prev = 0;
    always @(negedge game_clk) ctrl_neg = {a.controller_2, a.controller_1};
    always @(posedge a.game_clk_out) begin
        if (pulses == 0) exp_q.push_back(ctrl_neg);
        chk("pulse_during_latch", a.game_latch, 1'b0);
        rx_sh = {rx_sh[22:0], a.game_data};
        pulses++;
        pulses_tot++;
        t_rise = $time;
    end
    always @(negedge a.game_clk_out)
        if (pulses_tot > 0) chk("pulse_width", 32'($time - t_rise), 5);
    always @(posedge a.game_latch) begin
        logic [23:0] e;
        e = 24'hx;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("pulses_per_frame", pulses, 24);
        chk("rx_word", rx_sh, e);
        last_word = rx_sh;
        frames_rx++;
        pulses = 0;
        latch_prev = latch_t;
        latch_t = $time;
    end
    always @(negedge rstn) begin
        pulses = 0;
        exp_q.delete();
    end
    always @(posedge game_clk) begin
        if (a.game_latch === 1'b1) lat_n++;
        else if (lat_n != 0) begin
            chk("latch_width", lat_n, 4);
            lat_n = 0;
        end
        if (a.frame_done === 1'b1) done_n++;
    end
    // Receiver model for the short build (fixed controller words).
    logic [23:0] rx_b = '0, last_b = '0;
    int pulses_b = 0, frames_b = 0;
    time latch_tb = 0, latch_prev_b = 0;
    always @(posedge b.game_clk_out) begin
        rx_b = {rx_b[22:0], b.game_data};
        pulses_b++;
    end
    always @(posedge b.game_latch) begin
        chk("b_pulses_per_frame", pulses_b, 24);
        chk("b_rx_word", rx_b, 24'hA5A5A5);
        last_b = rx_b;
        pulses_b = 0;
        frames_b++;
        latch_prev_b = latch_tb;
        latch_tb = $time;
    end
    task automatic wait_frames(int n);
        int target, k;
        target = frames_rx + n;
        k = 0;
        while (frames_rx < target && k < 100 * n) begin
            step();
            k++;
        end
        chk("frame_timeout", 32'(frames_rx >= target), 1);
    endtask
    task automatic wait_pulses(int n);
        int k;
        k = 0;
        while (pulses < n && k < 200) begin
            step();
            k++;
        end
        chk("pulse_timeout", 32'(pulses >= n), 1);
    endtask
    task automatic chk_reset_outputs(string tag);
        chk({tag, "_data"}, a.game_data, 1'b1);
        chk({tag, "_latch"}, a.game_latch, 1'b0);
        chk({tag, "_busy"}, a.busy, 1'b0);
        chk({tag, "_done"}, a.frame_done, 1'b0);
        chk({tag, "_clk_out"}, a.game_clk_out, 1'b0);
    endtask
    initial begin
        logic [23:0] w, lw;
        int n, p;
        a.enable = 1'b0;
        a.controller_1 = 12'h123;
        a.controller_2 = 12'hABC;
        b.enable = 1'b1;
        b.controller_1 = 12'h5A5;
        b.controller_2 = 12'hA5A;
        repeat (3) step();
        chk_reset_outputs("reset");
        rstn = 1'b1;
        rstn_b = 1'b1;
        a.enable = 1'b1;
        n = 0;
        while (a.busy !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("enable_latency", 32'(n >= 2 && n <= 3), 1);
        wait_frames(1);
        chk("first_word", last_word, 24'hABC123);
        chk("first_ctrl1", last_word[11:0], 12'h123);
        chk("first_ctrl2", last_word[23:12], 12'hABC);
        wait_pulses(5);
        a.controller_1 = 12'hFFF;
        wait_frames(1);
        chk("midframe_change_old", last_word, 24'hABC123);
        chk("period", 32'(latch_t - latch_prev), 440);
        wait_frames(1);
        chk("midframe_change_new", last_word, 24'hABCFFF);
        chk("period", 32'(latch_t - latch_prev), 440);
        repeat (3) begin
            w = 24'($urandom);
            a.controller_1 = w[11:0];
            a.controller_2 = w[23:12];
            wait_frames(1);
            chk("random_word", last_word, w);
            chk("period", 32'(latch_t - latch_prev), 440);
        end
        wait_pulses(10);
        a.enable = 1'b0;
        p = frames_rx;
        n = 0;
        while (a.busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("drop_frame_completed", frames_rx, p + 1);
        chk("drop_idle_busy", a.busy, 1'b0);
        chk("drop_idle_data", a.game_data, 1'b1);
        chk("frame_done_count", done_n, frames_rx);
        p = pulses_tot;
        repeat (100) step();
        chk("idle_no_pulses", pulses_tot, p);
        chk("idle_no_latch", frames_rx, p == pulses_tot ? frames_rx : -1);
        a.enable = 1'b1;
        wait_pulses(10);
        lw = last_word;
        p = frames_rx;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("abort");
        w = 24'($urandom);
        a.controller_1 = w[11:0];
        a.controller_2 = w[23:12];
        repeat (5) step();
        chk("abort_no_latch", frames_rx, p);
        chk("abort_word_kept", last_word, lw);
        rstn = 1'b1;
        wait_frames(1);
        chk("fresh_frame_word", last_word, w);
        a.enable = 1'b0;
        n = 0;
        while (a.busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        chk("final_idle", a.busy, 1'b0);
        chk("final_done_count", done_n, frames_rx);
        chk("b_frames", 32'(frames_b > 10), 1);
        chk("b_period", 32'(latch_tb - latch_prev_b), 260);
        chk("b_ctrl1", last_b[11:0], 12'h5A5);
        chk("b_ctrl2", last_b[23:12], 12'hA5A);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tt_game_tx.md
# tt_game_tx

Gamepad-PMOD transmitter: serialises two 12-bit controller words onto the three-wire latch/clock/data gamepad interface. It acts as the far end of the receiver in `peri/ttgame`, and serves as a controller emulator for test boards and loopback benches. A gated copy of `game_clk` is forwarded, so the receiver sees exactly 24 clock pulses per frame and no pulses while latch is high.

## Interface
Parameters:
- `LATCH_CYCLES`, default 4: `game_clk` periods with `game_latch` high. Minimum 1. Must cover the receiver's 2-flop sync plus 1 system clock.
- `GAP_CYCLES`, default 16: idle `game_clk` periods after latch, before the next frame. Minimum 1.

Ports:
- `game_clk` in 1: free-running bit clock; block clock.
- `rstn` in 1: asynchronous, active-low reset.
- `enable` in 1: run frames continuously. Asynchronous to `game_clk`; synchronised internally.
- `controller_1` in 12: word sent second (frame bits 11:0).
- `controller_2` in 12: word sent first (frame bits 23:12).
- `game_clk_out` out 1: `game_clk` AND `clk_en`, forwarded to the receiver.
- `game_data` out 1: serial data, MSB of {controller_2, controller_1} first.
- `game_latch` out 1: frame latch strobe, active high.
- `busy` out 1: high in any state except IDLE.
- `frame_done` out 1: one `game_clk` period pulse on entry to GAP.

## Operation
- All state changes on the **falling** edge of `game_clk`. `clk_en` therefore changes only while `game_clk` is low, which keeps `game_clk_out` glitch-free. The receiver samples on the rising edge, giving half a period of setup and hold.
- `enable` passes through a 2-flop synchroniser clocked on the falling edge (`en_s`).
- FSM states and transitions:
  - **IDLE** → **SHIFT** when `en_s`=1.
  - **SHIFT**: 24 falling edges, `bit_cnt` 0..23, then → **LATCH**.
  - **LATCH**: `LATCH_CYCLES` falling edges, then → **GAP**.
  - **GAP**: `GAP_CYCLES` falling edges, then → **SHIFT** if `en_s`=1, else → **IDLE**.
- Entering SHIFT: `shreg` loads {controller_2, controller_1}, `game_data` = bit 23, `clk_en`=1. Each later SHIFT edge shifts left, bringing bits 22..0 onto `game_data`.
- Leaving SHIFT (24th falling edge): `clk_en`=0, `game_data`=1, `game_latch`=1.
- Entering GAP: `game_latch`=0, `frame_done`=1 for one period.
- Controller inputs are captured only at SHIFT entry. Changes mid-frame affect the next frame only.
- `enable` falling mid-frame: the current frame completes through GAP, then the block goes IDLE. There are no partial frames.
- Reset values (asserted immediately on `rstn` low, including mid-frame): state IDLE, `clk_en`=0, `game_data`=1, `game_latch`=0, `busy`=0, `frame_done`=0, `shreg`=0xFFFFFF, synchroniser 0. An aborted frame produces no latch, so the receiver keeps its previous word.

## Timing
- Frame period: 24 + `LATCH_CYCLES` + `GAP_CYCLES` `game_clk` periods (44 by default).
- `game_clk_out` pulses occur on rising edges R1..R24 after SHIFT entry F0. `game_data` = frame bit 23−k is stable across R(k+1).
- `game_latch` rises at F24, half a period after R24, and stays high for exactly `LATCH_CYCLES` periods.
- `enable` rising to first data bit: 2–3 falling edges (synchroniser plus FSM).
- Back-to-back frames: the last GAP edge is immediately followed by SHIFT entry, with no extra idle cycle.

## Structure
- Package `tt_game_pkg`:
  - `FRAME_BITS`=24, `CTRL_BITS`=12.
  - State enum {IDLE, SHIFT, LATCH, GAP}.
  - Shared with the receiver.
- Sub-module `game_clk_gate`: AND gate with an enable input, instantiated as a dedicated cell so CTS treats `game_clk_out` as a generated clock.
- Counters:
  - `bit_cnt`: 5 bits.
  - Latch/gap down-counter: $clog2(max(LATCH_CYCLES, GAP_CYCLES)+1) bits.

## Test plan
- Reset, `controller_1`=0x123, `controller_2`=0xABC, `enable`=1 → `game_data` on R1..R24 = 0xABC123, MSB first. `game_latch` high 4 periods. Receiver model reports 0x123 / 0xABC.
- Free-run 3 frames → exactly 24 `game_clk_out` pulses per frame, period 44, no pulses during latch/gap, no runt pulses, `frame_done` once per frame.
- Change `controller_1` to 0xFFF at bit 5 → current frame still carries 0x123; next frame carries 0xFFF.
- Drop `enable` at bit 10 → frame completes with latch and gap, then IDLE with `busy`=0, `game_data`=1 and no further pulses.
- Assert `rstn` at bit 10 → outputs at reset values immediately, no latch. Receiver word unchanged. After release, a full fresh frame follows.
- `LATCH_CYCLES`=1, `GAP_CYCLES`=1 build → period 26; receiver still captures 0x5A5 / 0xA5A correctly.
